// File: rtl/multicycle_chunk_adder_if.sv
// Handshake and operand/result bundle for multicycle_chunk_adder.
// master = producer/consumer side, slave = the adder.
interface multicycle_chunk_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/multicycle_chunk_adder.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit operand pair CHUNK bits per
// enabled clock, LSB chunk first, with a registered carry between chunks.
module multicycle_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   multicycle_chunk_adder_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("multicycle_chunk_adder: WIDTH must be a multiple of CHUNK");
   end

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic             accept;
   logic [CHUNK-1:0] a_ch;
   logic [CHUNK-1:0] b_ch;
   logic [CHUNK:0]   ch_full;
   logic             ch_cout;
   logic             msb_cin;
   logic [WIDTH-1:0] full;

   always_comb begin
      // NOTE: every signal here gets a value on every pass, so no latch is inferred.
      a_ch    = op_a[idx*CHUNK +: CHUNK];
      b_ch    = op_b[idx*CHUNK +: CHUNK];
      ch_full = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
      ch_cout = ch_full[CHUNK];
      // Carry into the MSB recovered from the MSB's own sum bit and operands.
      msb_cin = ch_full[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
      full    = partial;
      full[idx*CHUNK +: CHUNK] = ch_full[CHUNK-1:0];
   end

   assign bus.in_ready  = rst_n && enable && (state == IDLE);
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (state == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the operand/partial registers are plain flops, not a memory,
         // so resetting them costs nothing and keeps outputs deterministic.
         state   <= IDLE;
         idx     <= '0;
         carry   <= 1'b0;
         op_a    <= '0;
         op_b    <= '0;
         partial <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  // Subtraction is A + ~B + 1; cin is ignored in that mode.
                  op_a  <= bus.a;
                  op_b  <= bus.sub ? ~bus.b : bus.b;
                  carry <= bus.sub | bus.cin;
                  idx   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               if (enable) begin
                  partial <= full;
                  carry   <= ch_cout;
                  if (idx == LAST_IDX) begin
                     idx    <= '0;
                     sum_q  <= full;
                     cout_q <= ch_cout;
                     ovf_q  <= msb_cin ^ ch_cout;
                     state  <= DONE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
